// File: rtl/nios_cpu_pio_pkg.sv
// Shared register map constants for the indexed output PIO.
// Address decoding and the status bit position live here so the top and bench agree.
package nios_cpu_pio_pkg;

  localparam int BUS_WIDTH = 32;
  localparam int BUSY_BIT  = 31;

  typedef enum logic [1:0] {
    ADDR_DATA  = 2'd0,
    ADDR_SET   = 2'd1,
    ADDR_CLR   = 2'd2,
    ADDR_PULSE = 2'd3
  } reg_addr_e;

  function automatic logic is_write(input logic chipselect, input logic write_n);
    return chipselect && !write_n;
  endfunction

endpackage

// File: rtl/nios_cpu_pulse_timer.sv
// Down-counter behind the timed pulse: load restarts, counts to zero, then flags expiry.
// expire is high in the single cycle where the pulse mask must be dropped.
module nios_cpu_pulse_timer #(
  parameter int PULSE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy,
  output logic expire
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);

  logic [CW-1:0] counter_reg, counter_next;
  logic          busy_reg, busy_next;

  always_comb begin
    counter_next = counter_reg;
    busy_next    = busy_reg;
    if (load) begin
      counter_next = CW'(PULSE_CYCLES - 1);
      busy_next    = 1'b1;
    end else if (busy_reg) begin
      if (counter_reg == '0) begin
        busy_next = 1'b0;
      end else begin
        counter_next = counter_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_reg <= '0;
      busy_reg    <= 1'b0;
    end else begin
      counter_reg <= counter_next;
      busy_reg    <= busy_next;
    end
  end

  assign busy   = busy_reg;
  assign expire = busy_reg && (counter_reg == '0);

endmodule

// File: rtl/nios_cpu_index_output.sv
// Avalon-MM output PIO with load/set/clear registers and a change strobe.
// Define NIOS_CPU_INDEX_OUTPUT_PULSE_EN to add the timed pulse register at address 3.
module nios_cpu_index_output
  import nios_cpu_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                    PULSE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_strobe
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_bits;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [DATA_WIDTH-1:0] pulse_mask;
  logic                  busy;
  logic [DATA_WIDTH-1:0] port_next;
  logic [31:0]           rd_next;
  logic                  unused_writedata;

  assign wr_en            = is_write(chipselect, write_n);
  assign wr_bits          = writedata[DATA_WIDTH-1:0];
  assign unused_writedata = ^writedata;

  always_comb begin
    data_next = data_reg;
    if (wr_en) begin
      case (reg_addr_e'(address))
        ADDR_DATA: data_next = wr_bits;
        ADDR_SET:  data_next = data_reg | wr_bits;
        ADDR_CLR:  data_next = data_reg & ~wr_bits;
        default:   data_next = data_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= RESET_VALUE;
    end else begin
      data_reg <= data_next;
    end
  end

`ifdef NIOS_CPU_INDEX_OUTPUT_PULSE_EN
  logic                  pulse_load;
  logic                  pulse_expire;
  logic [DATA_WIDTH-1:0] pulse_mask_reg;

  // A zero-data write must not restart the count, so it never reaches the timer.
  assign pulse_load = wr_en && (reg_addr_e'(address) == ADDR_PULSE) && (|wr_bits);

  nios_cpu_pulse_timer #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_pulse_timer (
    .clk   (clk),
    .reset (reset),
    .load  (pulse_load),
    .busy  (busy),
    .expire(pulse_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_mask_reg <= '0;
    end else if (pulse_load) begin
      pulse_mask_reg <= pulse_mask_reg | wr_bits;
    end else if (pulse_expire) begin
      pulse_mask_reg <= '0;
    end
  end

  assign pulse_mask = pulse_mask_reg;
`else
  assign pulse_mask = '0;
  assign busy       = 1'b0;
`endif

  assign port_next = data_reg | pulse_mask;

  always_comb begin
    rd_next = '0;
    case (reg_addr_e'(address))
      ADDR_DATA: rd_next[DATA_WIDTH-1:0] = data_reg;
      ADDR_PULSE: begin
        rd_next[DATA_WIDTH-1:0] = pulse_mask;
        rd_next[BUSY_BIT]       = busy;
      end
      default: rd_next = '0;
    endcase
  end

  // Strobe compares against the currently driven pins, so no-op writes stay silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_port   <= RESET_VALUE;
      out_strobe <= 1'b0;
      readdata   <= '0;
    end else begin
      out_port   <= port_next;
      out_strobe <= (port_next != out_port);
      readdata   <= rd_next;
    end
  end

endmodule
